// File: rtl/ldpc_vnmsg_store.sv
// Up-message store for one VN cluster: NUMVNS lanes of MSGWIDTH bits, banked RAM with per-lane
// write mask, registered write-first read and a sequencer that zeroes every entry on request.
module ldpc_vnmsg_store #(
    parameter int NUMVNS     = 3,
    parameter int MSGWIDTH   = 17,
    parameter int FOLDFACTOR = 1,
    parameter int BANKLANES  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [NUMVNS-1:0]            wr_mask,
    input  logic [7+FOLDFACTOR-1:0]      wraddr,
    input  logic [NUMVNS*MSGWIDTH-1:0]   din,
    input  logic                         re,
    input  logic [7+FOLDFACTOR-1:0]      rdaddr,
    output logic [NUMVNS*MSGWIDTH-1:0]   dout,
    output logic                         dout_valid,
    input  logic                         clr_start,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int AW       = 7 + FOLDFACTOR;
    localparam int DEPTH    = 1 << AW;
    localparam int NUMBANKS = (NUMVNS + BANKLANES - 1) / BANKLANES;
    localparam int PADLANES = NUMBANKS * BANKLANES;
    localparam int BANKW    = BANKLANES * MSGWIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode the state register only, so they carry no input-to-output path.
    always_comb begin
        clr_busy = (state == CLEAR);
        clr_done = (state == DONE);
    end

    // The counter parks at zero on the last clear address instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)                          clr_cnt <= '0;
        else if (state == IDLE && clr_start) clr_cnt <= '0;
        else if (state == CLEAR)          clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + AW'(1);
    end

    // ---- p0: write-port arbitration between the clear sequencer and external writes
    logic                         clr_we_p0;
    logic [AW-1:0]                waddr_p0;
    logic [PADLANES-1:0]          lane_we_p0;
    logic [PADLANES*MSGWIDTH-1:0] wdata_p0;

    always_comb begin
        clr_we_p0  = (state == CLEAR) && !rst;
        waddr_p0   = clr_we_p0 ? clr_cnt : wraddr;
        lane_we_p0 = '0;
        wdata_p0   = '0;
        if (clr_we_p0) begin
            lane_we_p0[NUMVNS-1:0] = '1;
        end else if (we && state != CLEAR) begin
            lane_we_p0[NUMVNS-1:0]          = wr_mask;
            wdata_p0[NUMVNS*MSGWIDTH-1:0]   = din;
        end
    end

    logic [BANKW-1:0] rd_bank_p0 [NUMBANKS];

    for (genvar b = 0; b < NUMBANKS; b++) begin : g_bank
        logic [BANKW-1:0] mem [DEPTH];
        logic             bank_we;

        assign bank_we = |lane_we_p0[b*BANKLANES +: BANKLANES];

        always_ff @(posedge clk) begin
            if (bank_we) begin
                for (int l = 0; l < BANKLANES; l++) begin
                    if (lane_we_p0[b*BANKLANES+l])
                        mem[waddr_p0][l*MSGWIDTH +: MSGWIDTH] <= wdata_p0[(b*BANKLANES+l)*MSGWIDTH +: MSGWIDTH];
                end
            end
        end

        assign rd_bank_p0[b] = mem[rdaddr];
    end

    // Write-first: lanes written on this edge at the read address return the new data.
    logic [PADLANES*MSGWIDTH-1:0] rd_fwd_p0;

    always_comb begin
        for (int b = 0; b < NUMBANKS; b++)
            rd_fwd_p0[b*BANKW +: BANKW] = rd_bank_p0[b];
        for (int k = 0; k < PADLANES; k++) begin
            if (lane_we_p0[k] && waddr_p0 == rdaddr)
                rd_fwd_p0[k*MSGWIDTH +: MSGWIDTH] = wdata_p0[k*MSGWIDTH +: MSGWIDTH];
        end
    end

    // ---- p1: registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= re;
            if (re) dout <= rd_fwd_p0[NUMVNS*MSGWIDTH-1:0];
        end
    end

endmodule
